// File: rtl/ex_alu_stage_pkg.sv
// Shared definitions for the EX-stage ALU: the 4-bit ALU code set (also
// consumed by the ALU control unit) and the EX-stage FSM encoding.
package ex_alu_stage_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_MULA = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_ADDU = 4'b1000,
        ALU_SUBU = 4'b1001,
        ALU_XOR  = 4'b1010,
        ALU_SLTU = 4'b1011,
        ALU_NOR  = 4'b1100,
        ALU_SRA  = 4'b1101,
        ALU_LUI  = 4'b1110
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

endpackage

// File: rtl/ex_alu_stage_if.sv
// ID/EX -> EX/MEM bus of the execute-stage ALU. The pipeline front drives
// through the master side; the ALU stage sits on the slave side.
interface ex_alu_stage_if #(
    parameter int DATA_W = 32
);
    logic              InValid;
    logic [3:0]        ALUCtrl;
    logic [DATA_W-1:0] BusA;
    logic [DATA_W-1:0] BusB;
    logic [4:0]        Shamt;
    logic              Flush;
    logic              Busy;
    logic              OutValid;
    logic [DATA_W-1:0] ALUResult;
    logic              Zero;

    modport master (
        output InValid, ALUCtrl, BusA, BusB, Shamt, Flush,
        input  Busy, OutValid, ALUResult, Zero
    );

    modport slave (
        input  InValid, ALUCtrl, BusA, BusB, Shamt, Flush,
        output Busy, OutValid, ALUResult, Zero
    );
endinterface

// File: rtl/ex_alu_stage_mula.sv
// Shift-add multiplier with a private accumulator for MULA. One multiplier
// bit is consumed per step; the step on which the counter sits at MUL_W-1
// completes the operation and folds the product into ACC. A start or an
// idle cycle leaves ACC alone, so an aborted operation never touches it.
module mula_seq #(
    parameter int DATA_W = 32,
    parameter int MUL_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    input  logic [MUL_W-1:0]  op_a,
    input  logic [MUL_W-1:0]  op_b,
    output logic              done,
    output logic [DATA_W-1:0] sum
);
    localparam int CNT_W = (MUL_W > 1) ? $clog2(MUL_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_W - 1);

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [MUL_W-1:0]  mplier_q, mplier_d;
    logic [DATA_W-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] prod_step;

    // Next-state for the shift-add datapath, counter and accumulator.
    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
        sum       = acc_q + prod_step;
        done      = step && (cnt_q == CNT_LAST);
        if (start) begin
            mcand_d  = {{(DATA_W-MUL_W){1'b0}}, op_a};
            mplier_d = op_b;
            prod_d   = '0;
            cnt_d    = '0;
        end else if (step) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            prod_d   = prod_step;
            cnt_d    = cnt_q + CNT_W'(1);
            if (done) acc_d = sum;
        end
    end

    // Multiplier state; ACC is cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU: combinational op mux for single-cycle codes, an
// IDLE/MUL FSM that sequences MULA through mula_seq, and the registered
// EX/MEM result. Flush beats both acceptance and MULA completion.
module ex_alu_stage
    import ex_alu_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MUL_W  = 16
) (
    input  logic          CLK,
    input  logic          Reset_L,
    ex_alu_stage_if.slave bus
);
    ex_state_e         state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;

    logic [DATA_W-1:0] alu_res;
    logic              busy, is_mula, accept, mula_start, mula_step, mula_done;
    logic [DATA_W-1:0] mula_sum;

    // Single-cycle op mux; unused codes (including MULA and 4'b1111) give 0.
    always_comb begin
        alu_res = '0;
        case (bus.ALUCtrl)
            ALU_AND:            alu_res = bus.BusA & bus.BusB;
            ALU_OR:             alu_res = bus.BusA | bus.BusB;
            ALU_XOR:            alu_res = bus.BusA ^ bus.BusB;
            ALU_NOR:            alu_res = ~(bus.BusA | bus.BusB);
            ALU_ADD, ALU_ADDU:  alu_res = bus.BusA + bus.BusB;
            ALU_SUB, ALU_SUBU:  alu_res = bus.BusA - bus.BusB;
            ALU_SLT:            alu_res = DATA_W'($signed(bus.BusA) < $signed(bus.BusB));
            ALU_SLTU:           alu_res = DATA_W'(bus.BusA < bus.BusB);
            ALU_SLL:            alu_res = bus.BusB << bus.Shamt;
            ALU_SRL:            alu_res = bus.BusB >> bus.Shamt;
            ALU_SRA:            alu_res = $signed(bus.BusB) >>> bus.Shamt;
            ALU_LUI:            alu_res = DATA_W'({bus.BusB[15:0], 16'h0000});
            default:            alu_res = '0;
        endcase
    end

    mula_seq #(
        .DATA_W (DATA_W),
        .MUL_W  (MUL_W)
    ) u_mula (
        .clk   (CLK),
        .rst_n (Reset_L),
        .start (mula_start),
        .step  (mula_step),
        .op_a  (bus.BusA[MUL_W-1:0]),
        .op_b  (bus.BusB[MUL_W-1:0]),
        .done  (mula_done),
        .sum   (mula_sum)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: enter MUL on an accepted MULA, leave on flush or done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mula_start)                  state_d = ST_MUL;
            ST_MUL:  if (bus.Flush || mula_done)      state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: accept/step controls and next values of the result regs.
    always_comb begin
        busy        = (state_q == ST_MUL);
        is_mula     = (bus.ALUCtrl == ALU_MULA);
        accept      = !busy && bus.InValid && !bus.Flush;
        mula_start  = accept && is_mula;
        mula_step   = busy && !bus.Flush;
        out_valid_d = (accept && !is_mula) || mula_done;
        result_d    = result_q;
        zero_d      = zero_q;
        if (accept && !is_mula) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
        end else if (mula_done) begin
            result_d = mula_sum;
            zero_d   = (mula_sum == '0);
        end
    end

    // EX/MEM output registers; result and Zero hold between valid pulses.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.Busy      = busy;
    assign bus.OutValid  = out_valid_q;
    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_ex_alu_stage.sv
// Randomized self-checking bench for ex_alu_stage with a behavioural model:
// ops computed with plain arithmetic, MULA as acc + a*b on wide integers.
module tb_ex_alu_stage;
    import ex_alu_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_alu_stage_if #(.DATA_W(32)) bus();

    ex_alu_stage #(.DATA_W(32), .MUL_W(16)) dut (
        .CLK     (clk),
        .Reset_L (rst_n),
        .bus     (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] acc_m    = '0;
    logic [31:0] last_res = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            ALU_AND:           return a & b;
            ALU_OR:            return a | b;
            ALU_XOR:           return a ^ b;
            ALU_NOR:           return ~(a | b);
            ALU_ADD, ALU_ADDU: return 32'(longint'(a) + longint'(b));
            ALU_SUB, ALU_SUBU: return 32'(longint'(a) - longint'(b));
            ALU_SLT:           return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:          return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            ALU_SLL:           return 32'(longint'(b) * (64'd1 << sh));
            ALU_SRL:           return 32'(longint'(b) / (64'd1 << sh));
            ALU_SRA:           return 32'(sb >>> sh);
            ALU_LUI:           return 32'(longint'(b % 65536) * 65536);
            default:           return 32'd0;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.InValid = 1'b0;
        bus.Flush   = 1'b0;
        bus.ALUCtrl = 4'h0;
        bus.BusA    = '0;
        bus.BusB    = '0;
        bus.Shamt   = '0;
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic busy);
        chk({tag, ".ov"},   32'(bus.OutValid), 32'(ov));
        chk({tag, ".res"},  bus.ALUResult, last_res);
        chk({tag, ".zero"}, 32'(bus.Zero), 32'(last_res == 32'd0));
        chk({tag, ".busy"}, 32'(bus.Busy), 32'(busy));
    endtask

    // One single-cycle op; optional same-cycle flush drops it.
    task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input bit fl);
        @(negedge clk);
        bus.InValid = 1'b1; bus.ALUCtrl = c; bus.BusA = a; bus.BusB = b;
        bus.Shamt = sh; bus.Flush = fl;
        @(posedge clk); #1;
        bus.InValid = 1'b0; bus.Flush = 1'b0;
        if (!fl) last_res = ref_alu(c, a, b, sh);
        chk_out(tag, !fl, 1'b0);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        @(posedge clk); #1;
        chk_out(tag, 1'b0, 1'b0);
    endtask

    // MULA with optional flush at iteration flush_at (0 = none) and optional
    // junk InValid pulses while busy.
    task automatic do_mula(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int flush_at, input bit junk);
        @(negedge clk);
        bus.InValid = 1'b1; bus.ALUCtrl = ALU_MULA; bus.BusA = a; bus.BusB = b; bus.Flush = 1'b0;
        @(posedge clk); #1;
        bus.InValid = 1'b0;
        chk_out({tag, ".acc"}, 1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == flush_at) bus.Flush = 1'b1;
            else if (junk && ($urandom_range(0, 2) == 0)) begin
                bus.InValid = 1'b1;
                bus.ALUCtrl = 4'($urandom_range(0, 15));
                bus.BusA = $urandom; bus.BusB = $urandom;
            end
            @(posedge clk); #1;
            bus.InValid = 1'b0; bus.Flush = 1'b0;
            if (k == flush_at) begin
                chk_out({tag, ".flush"}, 1'b0, 1'b0);
                idle_cycle({tag, ".postflush"});
                return;
            end
            if (k < 16) begin
                chk({tag, ".busy"}, 32'(bus.Busy), 32'd1);
                chk({tag, ".ov"},   32'(bus.OutValid), 32'd0);
            end else begin
                acc_m = 32'(longint'(acc_m) + longint'(a[15:0]) * longint'(b[15:0]));
                last_res = acc_m;
                chk_out({tag, ".done"}, 1'b1, 1'b0);
            end
        end
        idle_cycle({tag, ".once"});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_out("reset0", 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        do_op("add_ovf", ALU_ADD,  32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0);
        chk("add_ovf.val", bus.ALUResult, 32'h8000_0000);
        do_op("sub_zero", ALU_SUB, 32'd5, 32'd5, 5'd0, 1'b0);
        chk("sub_zero.z", 32'(bus.Zero), 32'd1);
        do_op("slt",  ALU_SLT,  32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
        chk("slt.val", bus.ALUResult, 32'd1);
        do_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
        chk("sltu.val", bus.ALUResult, 32'd0);
        do_op("sra",  ALU_SRA,  32'h0, 32'h8000_0000, 5'd4, 1'b0);
        chk("sra.val", bus.ALUResult, 32'hF800_0000);
        do_op("srl",  ALU_SRL,  32'h0, 32'h8000_0000, 5'd4, 1'b0);
        chk("srl.val", bus.ALUResult, 32'h0800_0000);
        do_op("lui",  ALU_LUI,  32'h0, 32'h0000_1234, 5'd0, 1'b0);
        chk("lui.val", bus.ALUResult, 32'h1234_0000);
        do_op("code15", 4'hF, 32'h1234, 32'h5678, 5'd3, 1'b0);
        idle_cycle("idle1");

        do_mula("mula1", 32'd3, 32'd4, 0, 1'b1);
        chk("mula1.val", bus.ALUResult, 32'd12);
        do_mula("mula2", 32'h0000_FFFF, 32'h0000_FFFF, 0, 1'b1);
        chk("mula2.val", bus.ALUResult, 32'hFFFE_000D);

        do_op("flush_idle", ALU_ADD, 32'd1, 32'd2, 5'd0, 1'b1);
        chk("flush_idle.held", bus.ALUResult, 32'hFFFE_000D);

        // Async reset in the middle of a MULA.
        @(negedge clk);
        bus.InValid = 1'b1; bus.ALUCtrl = ALU_MULA; bus.BusA = 32'd5; bus.BusB = 32'd5;
        @(posedge clk); #1 bus.InValid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        acc_m = '0; last_res = '0;
        #1 chk_out("reset_mid", 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        do_mula("mula3", 32'd3, 32'd4, 0, 1'b0);
        do_mula("mula_fl", 32'd2, 32'd2, 5, 1'b0);
        do_mula("mula4", 32'd1, 32'd1, 0, 1'b0);
        chk("mula4.val", bus.ALUResult, 32'd13);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_mula("r_mula", $urandom, $urandom,
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0, 1'b1);
            end else begin
                logic [3:0] c;
                c = 4'($urandom_range(0, 15));
                if (c == ALU_MULA) c = ALU_XOR;
                do_op("r_op", c, $urandom, $urandom, 5'($urandom_range(0, 31)),
                      $urandom_range(0, 7) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Execute-stage ALU for the pipelined MIPS core. It consumes the 4-bit `ALUCtrl` code produced by the ALU control unit, together with the ID/EX operands, and produces a registered result for EX/MEM. Single-cycle ops complete in one clock. `MULA` (multiply-accumulate) runs as an iterative multi-cycle operation and stalls the front of the pipe through `Busy`.

## Interface
- `DATA_W`, 32: operand/result width. The ALU code set assumes 32.
- `MUL_W`, 16: multiplier operand width. It sets the `MULA` iteration count. Constraint: `MUL_W` ≤ `DATA_W`/2.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `Reset_L`  in  1  asynchronous, active-low reset.
- `InValid`  in  1  the EX-stage instruction is valid this cycle.
- `ALUCtrl`  in  4  operation code, using the shared ALU code set.
- `BusA`  in  `DATA_W`  operand A (rs).
- `BusB`  in  `DATA_W`  operand B (rt or immediate).
- `Shamt`  in  5  shift amount for SLL/SRL/SRA.
- `Flush`  in  1  synchronous kill of the in-flight instruction.
- `Busy`  out  1  `MULA` in progress; upstream must hold its instruction.
- `OutValid`  out  1  one-cycle pulse: `ALUResult` and `Zero` are valid.
- `ALUResult`  out  `DATA_W`  registered result.
- `Zero`  out  1  registered (`ALUResult` == 0).

## Operation
- **Op semantics:**
  - AND, OR, XOR: bitwise.
  - NOR: ~(A|B).
  - ADD, ADDU, SUB, SUBU: mod 2^32. No overflow trap; ADD and ADDU give identical results.
  - SLT: signed compare; SLTU: unsigned compare. Result is 1 or 0.
  - SLL, SRL: logical shift of B by `Shamt`. SRA: arithmetic shift of B by `Shamt`.
  - LUI: {B[15:0], 16'h0}.
  - Code 4'b1111 and any unknown code: result 0.
- **MULA:**
  - Result = ACC + (A[MUL_W-1:0] × B[MUL_W-1:0]), unsigned, truncated to `DATA_W`.
  - ACC is an internal `DATA_W` accumulator, loaded with the result on completion.
  - ACC is cleared only by reset.
- **FSM states:** IDLE, MUL.
  - IDLE with `InValid`=1 and a non-MULA code: register the result; `OutValid`=1 next cycle; stay in IDLE.
  - IDLE with `InValid`=1 and `MULA`: capture the operands internally, clear the partial product and the counter, go to MUL.
  - MUL: each edge consumes one multiplier bit (shift-add), and the counter increments.
  - At the edge where the counter reaches `MUL_W`-1: write ACC + product to both `ALUResult` and ACC, pulse `OutValid`, return to IDLE.
- `Busy` = (state == MUL), decoded combinationally from the state register.
- `InValid` while `Busy`=1 is ignored. Upstream is required to stall instead of presenting it.
- **Flush:**
  - In IDLE: the same-cycle `InValid` instruction is dropped, and `OutValid` is 0 next cycle.
  - In MUL: abort, go to IDLE, leave ACC unchanged, no `OutValid`.
  - Flush takes priority over `InValid` and over completion.
- `ALUResult` and `Zero` hold their last values when `OutValid`=0.

## Timing
- **Reset values:** `OutValid`=0, `ALUResult`=0, `Zero`=1, `Busy`=0, ACC=0, state=IDLE.
- Reset asserted mid-`MULA` aborts the operation immediately, asynchronously.
- **Single-cycle op** accepted at edge N: `OutValid`, `ALUResult` and `Zero` are valid after edge N. Latency 1.
- Back-to-back single-cycle ops are accepted every cycle.
- **MULA** accepted at edge N:
  - `Busy`=1 after edge N.
  - Iterations run on edges N+1..N+`MUL_W`.
  - At edge N+`MUL_W`: result written, `OutValid`=1, `Busy`=0 together.
- A new instruction may be accepted at edge N+`MUL_W`+1.
- `OutValid` never stays high for two cycles from a single `MULA`.

## Structure
- **Shared package / include:**
  - The 4-bit ALU code constants (AND, OR, ADD, SLL, SRL, MULA, SUB, SLT, ADDU, SUBU, XOR, SLTU, NOR, SRA, LUI), also used by the ALU control unit.
  - The FSM state encoding.
- **Sub-module `mula_seq`:** shift-add multiplier plus accumulator. It owns ACC, the counter, and the start/flush/done handshake.
- `ex_alu_stage` holds the combinational op mux, the FSM glue, and the output registers.

## Test plan
- **Reset:** assert `Reset_L`=0 mid-run. Outputs take their reset values immediately: `Zero`=1, `ALUResult`=0, `OutValid`=0, `Busy`=0.
- **Back-to-back single-cycle ops:**
  - ADD 0x7FFFFFFF + 1 → 0x80000000.
  - SUB 5 - 5 → 0 with `Zero`=1.
  - SLT 0xFFFFFFFF vs 1 → 1.
  - SLTU 0xFFFFFFFF vs 1 → 0.
  - Each op produces `OutValid` exactly one cycle later.
- **Shifts and LUI:**
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SRL 0x80000000 by 4 → 0x08000000.
  - LUI B=0x1234 → 0x12340000.
- **Two MULAs:**
  - 3×4 gives 12 at accept+16 with `Busy` high for 16 cycles.
  - A following 0xFFFF×0xFFFF gives 0xFFFE0001 + 12 = 0xFFFE000D.
  - `InValid` pulsed while `Busy`=1 has no effect.
- **Flush mid-MULA:**
  - Start 2×2, assert `Flush` at iteration 5: no `OutValid`, `Busy`=0 next cycle.
  - A subsequent MULA 1×1 then gives 12+1 = 13, confirming ACC was unchanged by the aborted operation.
- **Flush in IDLE:** `Flush` coinciding with `InValid` ADD → no `OutValid`; the previous `ALUResult` is held.
